cornet_bus_seq: RTL and testbench

Parametrised multi-channel bus sequencer for the Cornet CPU family. It arbitrates between `NUM_CH` requesters, such as instruction fetch, operand read and data write, and serialises each multi-byte little-endian transaction onto the 8-bit system bus. It replaces the single-channel, read-only, 1/2-byte bus logic embedded in the current core and sits between the CPU sequencers and the memory/bus fabric.

---
 rtl/cornet_bus_pkg.sv | 21 ++
 rtl/cornet_rr_arbiter.sv | 32 +++
 rtl/cornet_bus_seq.sv | 163 ++++++++++++++++
 tb/tb_cornet_bus_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cornet_bus_pkg.sv
// Shared types, limits and helpers for the Cornet multi-channel bus sequencer.
// Contents: sequencer state enum, parameter limits, clog2 helper (minimum 1).
// Used by cornet_bus_seq and cornet_rr_arbiter through a wildcard import.
package cornet_bus_pkg;

   localparam int MAX_BYTES_LIMIT = 4;
   localparam int NUM_CH_LIMIT    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Index/length field width; never narrower than one bit.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/cornet_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
// Ports: req (per-channel request), ptr (search start), grant (index), valid.
// No state; the caller owns and advances ptr.
module cornet_rr_arbiter
   import cornet_bus_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [IDX_W-1:0]  grant,
   output logic              valid
);

   logic [IDX_W-1:0] idx;

   // Scan from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = IDX_W'((int'(ptr) + i) % NUM_CH);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cornet_bus_seq.sv
// Multi-channel bus sequencer: round-robin grant, serialises little-endian
// transactions onto an 8-bit bus. Ports: ch_* requester side (req/we/len/addr/
// wdata in, ack/rdata out); bus side bus_addr, rd_req/rd_ack/rd_data, wr_data/
// wr_enable. All outputs registered. Macro CORNET_BUS_WRITE_EN enables writes;
// without it every transaction is a read and the write outputs are tied 0.
module cornet_bus_seq
   import cornet_bus_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 16,
   parameter int MAX_BYTES = 2,
   parameter int LEN_W     = clog2_min1(MAX_BYTES)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CH-1:0]             ch_req,
   input  logic [NUM_CH-1:0]             ch_we,
   input  logic [NUM_CH*LEN_W-1:0]       ch_len,
   input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
   input  logic [NUM_CH*8*MAX_BYTES-1:0] ch_wdata,
   output logic [NUM_CH-1:0]             ch_ack,
   output logic [8*MAX_BYTES-1:0]        ch_rdata,
   output logic [ADDR_W-1:0]             bus_addr,
   output logic                          rd_req,
   input  logic                          rd_ack,
   input  logic [7:0]                    rd_data,
   output logic [7:0]                    wr_data,
   output logic                          wr_enable
);

   localparam int IDX_W = clog2_min1(NUM_CH);
   localparam int CNT_W = LEN_W + 1;   // write counter runs one past len
   localparam int DAT_W = 8 * MAX_BYTES;

   state_t            state, state_nx;
   logic [IDX_W-1:0]  rr_ptr, gnt_idx, id;
   logic              gnt_vld;
   logic [ADDR_W-1:0] base, sel_addr;
   logic [LEN_W-1:0]  len, sel_len, raw_len;
   logic              sel_we;
   logic [CNT_W-1:0]  cnt, cnt_inc;
   logic [DAT_W-1:0]  shadow, rd_merged;
   logic              last_rd;

   cornet_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
      .req   (ch_req),
      .ptr   (rr_ptr),
      .grant (gnt_idx),
      .valid (gnt_vld)
   );

   assign raw_len  = ch_len[gnt_idx*LEN_W +: LEN_W];
   assign sel_len  = (int'(raw_len) > MAX_BYTES - 1) ? LEN_W'(MAX_BYTES - 1) : raw_len;
   assign sel_addr = ch_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign cnt_inc  = cnt + CNT_W'(1);
   assign last_rd  = rd_ack && (cnt == CNT_W'(len));

`ifdef CORNET_BUS_WRITE_EN
   logic [DAT_W-1:0] wbuf, sel_wdata;
   assign sel_we    = ch_we[gnt_idx];
   assign sel_wdata = ch_wdata[gnt_idx*DAT_W +: DAT_W];
`else
   logic unused_wr;
   assign unused_wr = &{1'b0, ch_we, ch_wdata};
   assign sel_we    = 1'b0;
   assign wr_enable = 1'b0;
   assign wr_data   = 8'h00;
`endif

   // Result as it will look once the current byte lands, bytes above len zeroed.
   always_comb begin
      rd_merged = shadow;
      rd_merged[cnt[LEN_W-1:0]*8 +: 8] = rd_data;
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (b > int'(len)) rd_merged[b*8 +: 8] = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (gnt_vld) state_nx = sel_we ? WRITE : READ;
         READ:  if (last_rd) state_nx = DONE;
`ifdef CORNET_BUS_WRITE_EN
         WRITE: if (cnt > CNT_W'(len)) state_nx = DONE;
`endif
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr    <= '0;
         id        <= '0;
         base      <= '0;
         len       <= '0;
         cnt       <= '0;
         shadow    <= '0;
         ch_ack    <= '0;
         ch_rdata  <= '0;
         bus_addr  <= '0;
         rd_req    <= 1'b0;
`ifdef CORNET_BUS_WRITE_EN
         wbuf      <= '0;
         wr_enable <= 1'b0;
         wr_data   <= 8'h00;
`endif
      end else begin
         ch_ack <= '0;
         case (state)
            IDLE: if (gnt_vld) begin
               id       <= gnt_idx;
               rr_ptr   <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
               base     <= sel_addr;
               len      <= sel_len;
               bus_addr <= sel_addr;
               cnt      <= '0;
`ifdef CORNET_BUS_WRITE_EN
               if (sel_we) begin
                  // First strobe goes out with the grant itself.
                  wbuf      <= sel_wdata;
                  wr_enable <= 1'b1;
                  wr_data   <= sel_wdata[7:0];
                  cnt       <= CNT_W'(1);
               end else
`endif
               rd_req <= 1'b1;
            end
            READ: if (rd_ack) begin
               shadow[cnt[LEN_W-1:0]*8 +: 8] <= rd_data;
               if (last_rd) begin
                  rd_req   <= 1'b0;
                  ch_rdata <= rd_merged;
                  ch_ack   <= NUM_CH'(1) << id;
               end else begin
                  cnt      <= cnt_inc;
                  bus_addr <= base + ADDR_W'(cnt_inc);
               end
            end
`ifdef CORNET_BUS_WRITE_EN
            WRITE: begin
               if (cnt > CNT_W'(len)) begin
                  wr_enable <= 1'b0;
                  ch_ack    <= NUM_CH'(1) << id;
               end else begin
                  wr_data  <= wbuf[cnt[LEN_W-1:0]*8 +: 8];
                  bus_addr <= base + ADDR_W'(cnt);
                  cnt      <= cnt_inc;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cornet_bus_seq.sv
// Self-checking bench for cornet_bus_seq (NUM_CH=2, ADDR_W=16, MAX_BYTES=3).
// Table of directed transactions plus hand sequences for reset, arbitration,
// spurious rd_ack and mid-transfer reset. Expectations follow CORNET_BUS_WRITE_EN.
module tb_cornet_bus_seq;

   localparam int NUM_CH    = 2;
   localparam int ADDR_W    = 16;
   localparam int MAX_BYTES = 3;
   localparam int LEN_W     = 2;
   localparam int DAT_W     = 24;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_CH-1:0]        ch_req, ch_we, ch_ack;
   logic [NUM_CH*LEN_W-1:0]  ch_len;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*DAT_W-1:0]  ch_wdata;
   logic [DAT_W-1:0]         ch_rdata;
   logic [ADDR_W-1:0]        bus_addr;
   logic                     rd_req, rd_ack, wr_enable;
   logic [7:0]               rd_data, wr_data;

   always #5 clk = ~clk;

   cornet_bus_seq #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
      .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_we(ch_we), .ch_len(ch_len),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata),
      .bus_addr(bus_addr), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_data(wr_data), .wr_enable(wr_enable)
   );

   int          checks = 0;
   int          errors = 0;
   int          rd_lat = 0;
   logic        spur   = 1'b0;
   logic [23:0] strobes[$];

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      case (a)
         16'h1234: return 8'h34;
         16'h1235: return 8'h12;
         16'h2000: return 8'hA1;
         16'h2001: return 8'hB2;
         16'h2002: return 8'hC5;
         16'hFFFF: return 8'hC3;
         16'h0000: return 8'hD4;
         16'h3000: return 8'h11;
         16'h3001: return 8'h22;
         16'h3002: return 8'h33;
         16'h3003: return 8'h44;
         default:  return 8'hEE;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory model: acks rd_lat cycles after seeing a request for the current address.
   initial begin
      int wait_cnt;
      rd_ack   = 1'b0;
      rd_data  = 8'h00;
      wait_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         rd_ack = 1'b0;
         if (spur) begin
            rd_ack  = 1'b1;
            rd_data = 8'h99;
         end else if (rd_req) begin
            if (wait_cnt == rd_lat) begin
               rd_ack   = 1'b1;
               rd_data  = mem_byte(bus_addr);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (wr_enable) strobes.push_back({bus_addr, wr_data});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic run_txn(input int ch, input logic we, input logic [1:0] len,
                          input logic [15:0] addr, input logic [23:0] wdata,
                          output logic [1:0] ack, output int cyc);
      @(negedge clk);
      ch_we[ch]              = we;
      ch_len[ch*LEN_W +: LEN_W]   = len;
      ch_addr[ch*ADDR_W +: ADDR_W] = addr;
      ch_wdata[ch*DAT_W +: DAT_W]  = wdata;
      ch_req[ch]             = 1'b1;
      ack = '0;
      cyc = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (ch_ack != '0) begin
            ack = ch_ack;
            cyc = i;
            break;
         end
      end
      ch_req[ch] = 1'b0;
      if (cyc == 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout actual=none required=ack ch=%0d", ch);
      end
   endtask

   typedef struct {
      int          ch;
      logic        we;
      logic [1:0]  len;
      logic [15:0] addr;
      logic [23:0] wdata;
      int          lat;
      logic        spur;
      logic [1:0]  exp_ack;
      logic [23:0] exp_rdata;
      int          exp_cyc;
      int          exp_strb;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [1:0]  ack;
      int          cyc, n, seen;
      logic [1:0]  arb_ack[4];
      logic [23:0] arb_rd[4];
      logic [23:0] w;
      logic [15:0] a;

      reset_n  = 1'b0;
      ch_req   = '0;
      ch_we    = '0;
      ch_len   = '0;
      ch_addr  = '0;
      ch_wdata = '0;

      //            ch we len addr      wdata      lat spur ack    rdata      cyc strb
      vecs[0] = '{0, 1'b0, 2'd1, 16'h1234, 24'h0, 1, 1'b0, 2'b01, 24'h001234, 5, 0};
      vecs[1] = '{1, 1'b0, 2'd2, 16'h2000, 24'h0, 0, 1'b0, 2'b10, 24'hC5B2A1, 4, 0};
      vecs[2] = '{0, 1'b0, 2'd0, 16'h3000, 24'h0, 2, 1'b0, 2'b01, 24'h000011, 4, 0};
`ifdef CORNET_BUS_WRITE_EN
      vecs[3] = '{1, 1'b1, 2'd1, 16'hFFFF, 24'h00BEEF, 1, 1'b0, 2'b10, 24'h000011, 3, 2};
      vecs[4] = '{0, 1'b1, 2'd2, 16'h3000, 24'h123456, 0, 1'b0, 2'b01, 24'h000011, 4, 3};
`else
      vecs[3] = '{1, 1'b1, 2'd1, 16'hFFFF, 24'h00BEEF, 1, 1'b0, 2'b10, 24'h00D4C3, 5, 0};
      vecs[4] = '{0, 1'b1, 2'd2, 16'h3000, 24'h123456, 0, 1'b0, 2'b01, 24'h332211, 4, 0};
`endif
      // len=3 exceeds MAX_BYTES-1 and clamps to a 3-byte read.
      vecs[5] = '{1, 1'b0, 2'd3, 16'h3000, 24'h0, 0, 1'b1, 2'b10, 24'h332211, 4, 0};

      repeat (2) @(negedge clk);
      check("rst_bus_addr", 32'(bus_addr), 0);
      check("rst_rd_req", 32'(rd_req), 0);
      check("rst_wr_enable", 32'(wr_enable), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_ch_ack", 32'(ch_ack), 0);
      check("rst_ch_rdata", 32'(ch_rdata), 0);
      reset_n = 1'b1;

      // Both channels request continuously from rr_ptr=0: grants alternate 0,1,0,1.
      rd_lat = 0;
      @(negedge clk);
      ch_addr = {16'h2000, 16'h3000};
      ch_len  = '0;
      ch_we   = '0;
      ch_req  = 2'b11;
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk);
         if (ch_ack != '0) begin
            arb_ack[n] = ch_ack;
            arb_rd[n]  = ch_rdata;
            n++;
         end
      end
      ch_req = '0;
      check("arb_count", 32'(n), 4);
      for (int k = 0; k < n; k++) begin
         check($sformatf("arb_ack%0d", k), 32'(arb_ack[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("arb_rdata%0d", k), 32'(arb_rd[k]), (k % 2 == 0) ? 32'h11 : 32'hA1);
      end
      repeat (3) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         rd_lat = vecs[v].lat;
         if (vecs[v].spur) begin
            @(negedge clk) spur = 1'b1;
            @(negedge clk) spur = 1'b0;
            repeat (2) @(negedge clk);
            check("spur_no_ack", 32'(ch_ack), 0);
            check("spur_rd_req", 32'(rd_req), 0);
            check("spur_rdata", 32'(ch_rdata), 32'(vecs[v-1].exp_rdata));
         end
         strobes.delete();
         run_txn(vecs[v].ch, vecs[v].we, vecs[v].len, vecs[v].addr, vecs[v].wdata, ack, cyc);
         check($sformatf("v%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         check($sformatf("v%0d_rdata", v), 32'(ch_rdata), 32'(vecs[v].exp_rdata));
         check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
         check($sformatf("v%0d_strobes", v), 32'(strobes.size()), 32'(vecs[v].exp_strb));
         w = vecs[v].wdata;
         for (int i = 0; i < strobes.size() && i < vecs[v].exp_strb; i++) begin
            a = vecs[v].addr + 16'(i);
            check($sformatf("v%0d_s%0d_addr", v, i), 32'(strobes[i][23:8]), 32'(a));
            check($sformatf("v%0d_s%0d_data", v, i), 32'(strobes[i][7:0]), 32'(w[i*8 +: 8]));
         end
         repeat (2) @(negedge clk);
      end

      // Reset after the first of two read bytes: everything clears, no ack.
      rd_lat = 1;
      @(negedge clk);
      ch_we[0]      = 1'b0;
      ch_len[1:0]   = 2'd1;
      ch_addr[15:0] = 16'h1234;
      ch_req[0]     = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rd_req", 32'(rd_req), 1);
      check("mid_bus_addr", 32'(bus_addr), 32'h1235);
      reset_n = 1'b0;
      #1;
      check("arst_bus_addr", 32'(bus_addr), 0);
      check("arst_rd_req", 32'(rd_req), 0);
      check("arst_ch_ack", 32'(ch_ack), 0);
      check("arst_ch_rdata", 32'(ch_rdata), 0);
      check("arst_wr_enable", 32'(wr_enable), 0);
      check("arst_wr_data", 32'(wr_data), 0);
      ch_req = '0;
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ch_ack != '0) seen++;
      end
      check("arst_no_ack", 32'(seen), 0);
      run_txn(1, 1'b0, 2'd1, 16'h1234, 24'h0, ack, cyc);
      check("post_rst_ack", 32'(ack), 32'h2);
      check("post_rst_rdata", 32'(ch_rdata), 32'h001234);
      check("post_rst_cycles", 32'(cyc), 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
